keypad_operand_entry: RTL and testbench

Input-side front end for the 4-bit add/subtract datapath and its seven-segment displays. It scans a 4x4 hex keypad by driving columns and reading rows, debounces the result, and runs a small entry FSM. The FSM captures operand a0, then operand a1, and latches the add/subtract select s. Its outputs connect directly to the a0/a1/s inputs of the adder.

---
 rtl/keypad_operand_entry_pkg.sv | 29 ++
 rtl/keypad_operand_entry_if.sv | 8 +
 rtl/keypad_operand_entry_scan.sv | 172 +++++++++++++++++
 rtl/keypad_operand_entry.sv | 102 ++++++++++
 tb/tb_keypad_operand_entry.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_operand_entry_pkg.sv
// Shared types for the keypad operand entry front end: state encodings,
// sweep classes and the operand bit-order helper.
package lab_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    READY   = 2'b10
  } entry_state_e;

  typedef enum logic [1:0] {
    DEB_IDLE      = 2'b00,
    DEB_PRESSING  = 2'b01,
    DEB_HELD      = 2'b10,
    DEB_RELEASING = 2'b11
  } deb_state_e;

  typedef enum logic [1:0] {
    SWEEP_NONE   = 2'b00,
    SWEEP_SINGLE = 2'b01,
    SWEEP_MULTI  = 2'b10
  } sweep_class_e;

  // The adder expects operands with bit 3 as the LSB.
  function automatic logic [3:0] bit_rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/keypad_operand_entry_if.sv
// Accepted-key handshake between the keypad scanner and the entry FSM.
interface keypad_operand_entry_if;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (output key_code, output key_valid);
  modport slave  (input  key_code, input  key_valid);
endinterface

// File: rtl/keypad_operand_entry_scan.sv
// 4x4 keypad column scanner with row synchronizer, per-sweep classifier
// and a sweep-granular debounce FSM producing one pulse per accepted key.
module keypad_scan
  import lab_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_SWEEPS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    row_n,
  output logic [3:0]                    col_n,
  keypad_operand_entry_if.master        key_if
);

  localparam int unsigned         DIV_W      = $clog2(SCAN_DIV);
  localparam int unsigned         CNT_W      = $clog2(DEB_SWEEPS + 1);
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]    DEB_TARGET = CNT_W'(DEB_SWEEPS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       code_q, code_d;

  deb_state_e       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  logic             dwell_end;
  logic             sweep_done;
  logic [3:0]       row_hits;
  logic [2:0]       col_cnt;
  logic [1:0]       row_idx;
  logic [1:0]       hits_base;
  logic [3:0]       code_base;
  logic [2:0]       hit_sum;
  logic [1:0]       hits_new;
  logic [3:0]       code_new;
  sweep_class_e     sweep_class;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_run;

  assign dwell_end = (div_q == DIV_LAST);
  assign row_hits  = ~row_s2_q;

  // Hits accumulate across the four columns of a sweep and saturate at two,
  // which is all the classifier needs to tell SINGLE from MULTI.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    col_d   = col_q;
    col_n_d = col_n_q;
    hits_d  = hits_q;
    code_d  = code_q;
    col_cnt = '0;
    row_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (row_hits[i]) begin
        col_cnt = col_cnt + 3'd1;
        row_idx = 2'(i);
      end
    end
    hits_base = (col_q == 2'd0) ? 2'd0 : hits_q;
    code_base = (col_q == 2'd0) ? 4'd0 : code_q;
    hit_sum   = {1'b0, hits_base} + col_cnt;
    hits_new  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_new  = (col_cnt != 3'd0) ? {row_idx, col_q} : code_base;
    if (dwell_end) begin
      div_d   = '0;
      col_d   = col_q + 2'd1;
      col_n_d = ~(4'b0001 << col_d);
      hits_d  = hits_new;
      code_d  = code_new;
    end
    sweep_done = dwell_end && (col_q == 2'd3);
    case (hits_new)
      2'd0:    sweep_class = SWEEP_NONE;
      2'd1:    sweep_class = SWEEP_SINGLE;
      default: sweep_class = SWEEP_MULTI;
    endcase
  end

  always_comb begin
    deb_d       = deb_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    cnt_inc     = (cnt_q == DEB_TARGET) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_run     = CNT_W'(1);
    if (sweep_done) begin
      case (deb_q)
        DEB_IDLE, DEB_PRESSING: begin
          if (sweep_class == SWEEP_SINGLE) begin
            if ((deb_q == DEB_PRESSING) && (code_new == cand_q)) begin
              cnt_run = cnt_inc;
            end
            cand_d = code_new;
            if (cnt_run == DEB_TARGET) begin
              deb_d       = DEB_HELD;
              cnt_d       = '0;
              key_code_d  = code_new;
              key_valid_d = 1'b1;
            end else begin
              deb_d = DEB_PRESSING;
              cnt_d = cnt_run;
            end
          end else begin
            deb_d = DEB_IDLE;
            cnt_d = '0;
          end
        end
        default: begin
          if (sweep_class == SWEEP_NONE) begin
            if (deb_q == DEB_RELEASING) begin
              cnt_run = cnt_inc;
            end
            if (cnt_run == DEB_TARGET) begin
              deb_d = DEB_IDLE;
              cnt_d = '0;
            end else begin
              deb_d = DEB_RELEASING;
              cnt_d = cnt_run;
            end
          end else begin
            deb_d = DEB_HELD;
            cnt_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      col_q       <= '0;
      col_n_q     <= 4'b1110;
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      hits_q      <= '0;
      code_q      <= '0;
      deb_q       <= DEB_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      row_s1_q    <= row_n;
      row_s2_q    <= row_s1_q;
      hits_q      <= hits_d;
      code_q      <= code_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_n            = col_n_q;
  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: scans the keypad, then captures a0, a1 and the
// add/subtract select for the 4-bit adder.
module keypad_operand_entry
  import lab_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_SWEEPS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  input  logic       sub_sw,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic       s,
  output logic       operands_valid,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [1:0] entry_state
);

  keypad_operand_entry_if key_if ();

  keypad_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_SWEEPS (DEB_SWEEPS)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .row_n  (row_n),
    .col_n  (col_n),
    .key_if (key_if)
  );

  logic         sub_s1_q, sub_s2_q;
  entry_state_e state_q, state_d;
  logic [3:0]   a0_q, a0_d;
  logic [3:0]   a1_q, a1_d;
  logic         s_q, s_d;
  logic         ov_q, ov_d;
  logic [3:0]   key_rev;

  assign key_rev = bit_rev4(key_if.key_code);

  always_comb begin
    state_d = state_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    s_d     = s_q;
    ov_d    = ov_q;
    if (key_if.key_valid) begin
      case (state_q)
        ENTER_A: begin
          a0_d    = key_rev;
          state_d = ENTER_B;
        end
        ENTER_B: begin
          a1_d    = key_rev;
          s_d     = sub_s2_q;
          ov_d    = 1'b1;
          state_d = READY;
        end
        default: begin
          a0_d    = key_rev;
          a1_d    = '0;
          ov_d    = 1'b0;
          state_d = ENTER_B;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_s1_q <= 1'b0;
      sub_s2_q <= 1'b0;
      state_q  <= ENTER_A;
      a0_q     <= '0;
      a1_q     <= '0;
      s_q      <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      sub_s1_q <= sub_sw;
      sub_s2_q <= sub_s1_q;
      state_q  <= state_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      s_q      <= s_d;
      ov_q     <= ov_d;
    end
  end

  assign a0             = a0_q;
  assign a1             = a1_q;
  assign s              = s_q;
  assign operands_valid = ov_q;
  assign entry_state    = state_q;
  assign key_code       = key_if.key_code;
  assign key_valid      = key_if.key_valid;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Randomized and directed bench for keypad_operand_entry against a
// sweep-level behavioural model of the keypad, debounce and entry rules.
module tb_keypad_operand_entry;

  localparam int unsigned SDIV = 4;
  localparam int unsigned DEB  = 2;
  localparam int unsigned SWEEP_CYC = 4 * SDIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       sub_sw = 1'b0;
  logic [3:0] a0, a1;
  logic       s, operands_valid;
  logic [1:0] entry_state;
  logic [15:0] mask = '0;

  keypad_operand_entry_if kif ();

  keypad_operand_entry #(
    .SCAN_DIV   (SDIV),
    .DEB_SWEEPS (DEB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .col_n          (col_n),
    .row_n          (row_n),
    .sub_sw         (sub_sw),
    .a0             (a0),
    .a1             (a1),
    .s              (s),
    .operands_valid (operands_valid),
    .key_code       (kif.key_code),
    .key_valid      (kif.key_valid),
    .entry_state    (entry_state)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit         armed;
  int         run_len, cand, none_run;
  logic [3:0] m_code, m_a0, m_a1;
  logic       m_s, m_ov;
  logic [1:0] m_state;

  task automatic model_reset();
    armed = 1; run_len = 0; cand = -1; none_run = 0;
    m_code = '0; m_a0 = '0; m_a1 = '0; m_s = 1'b0; m_ov = 1'b0; m_state = 2'b00;
  endtask

  function automatic int key_index(input logic [15:0] m);
    for (int b = 0; b < 16; b++) if (m[b]) return b;
    return -1;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[3-b] = v[b];
    return r;
  endfunction

  // One completed sweep: returns 1 when it accepts a key.
  task automatic model_sweep(input logic [15:0] m, output bit acc, output int code);
    int pc;
    pc = $countones(m);
    acc = 0;
    code = key_index(m);
    if (armed) begin
      if (pc == 1) begin
        if (run_len > 0 && code == cand) run_len++;
        else begin cand = code; run_len = 1; end
        if (run_len >= DEB) begin
          acc = 1; armed = 0; run_len = 0; none_run = 0;
        end
      end else run_len = 0;
    end else begin
      if (pc == 0) begin
        none_run++;
        if (none_run >= DEB) begin armed = 1; none_run = 0; run_len = 0; end
      end else none_run = 0;
    end
  endtask

  task automatic model_entry(input logic [3:0] code, input logic sw);
    case (m_state)
      2'b00: begin m_a0 = rev4(code); m_state = 2'b01; end
      2'b01: begin m_a1 = rev4(code); m_s = sw; m_ov = 1'b1; m_state = 2'b10; end
      default: begin m_a0 = rev4(code); m_a1 = '0; m_ov = 1'b0; m_state = 2'b01; end
    endcase
  endtask

  task automatic check_outputs(input logic exp_kv, input logic [3:0] exp_col);
    chk("col_n", col_n, exp_col);
    chk("key_valid", kif.key_valid, exp_kv);
    chk("key_code", kif.key_code, m_code);
    chk("a0", a0, m_a0);
    chk("a1", a1, m_a1);
    chk("s", s, m_s);
    chk("operands_valid", operands_valid, m_ov);
    chk("entry_state", entry_state, m_state);
  endtask

  // Called at a negedge on a sweep boundary; ncyc < SWEEP_CYC aborts mid-sweep.
  task automatic run_sweep(input logic [15:0] m, input logic sw, input int ncyc);
    bit acc;
    int code;
    logic [3:0] ecol;
    mask = m;
    sub_sw = sw;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      acc = 0;
      if (i == SWEEP_CYC) begin
        model_sweep(m, acc, code);
        if (acc) m_code = 4'(code);
      end
      ecol = ~(4'b0001 << ((i % SWEEP_CYC) / SDIV));
      check_outputs(acc, ecol);
      if (acc) model_entry(m_code, sw);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0, 4'b1110);
    repeat (2) @(negedge clk);
    check_outputs(1'b0, 4'b1110);
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] K1 = 16'h0002;
  localparam logic [15:0] K2 = 16'h0004;
  localparam logic [15:0] K3 = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K6 = 16'h0040;
  localparam logic [15:0] K9 = 16'h0200;

  initial begin
    logic [15:0] cur;
    logic        sw;
    int          pick;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single key held for three sweeps, then released
    repeat (3) run_sweep(K1, 1'b0, SWEEP_CYC);
    chk("t2_key_code", kif.key_code, 4'd1);
    chk("t2_a0", a0, 4'b1000);
    repeat (2) run_sweep('0, 1'b0, SWEEP_CYC);

    // Bounce on key 6
    run_sweep(K6, 1'b0, SWEEP_CYC);
    run_sweep('0, 1'b0, SWEEP_CYC);
    repeat (2) run_sweep(K6, 1'b0, SWEEP_CYC);
    chk("t3_key_code", kif.key_code, 4'd6);
    repeat (2) run_sweep('0, 1'b0, SWEEP_CYC);

    // Two keys together never accept
    @(negedge clk);
    do_reset();
    repeat (4) run_sweep(16'h0021, 1'b0, SWEEP_CYC);
    chk("t4_entry_state", entry_state, 2'b00);
    repeat (2) run_sweep('0, 1'b0, SWEEP_CYC);

    // Full operand entry with subtract selected
    repeat (2) run_sweep(K3, 1'b0, SWEEP_CYC);
    repeat (2) run_sweep('0, 1'b1, SWEEP_CYC);
    repeat (2) run_sweep(K5, 1'b1, SWEEP_CYC);
    run_sweep('0, 1'b0, SWEEP_CYC);
    chk("t5_a0", a0, 4'b1100);
    chk("t5_a1", a1, 4'b1010);
    chk("t5_s", s, 1'b1);
    chk("t5_ov", operands_valid, 1'b1);
    chk("t5_state", entry_state, 2'b10);
    run_sweep('0, 1'b0, SWEEP_CYC);
    repeat (2) run_sweep(K2, 1'b0, SWEEP_CYC);
    run_sweep('0, 1'b0, SWEEP_CYC);
    chk("t5b_a0", a0, 4'b0100);
    chk("t5b_a1", a1, 4'b0000);
    chk("t5b_s", s, 1'b1);
    chk("t5b_ov", operands_valid, 1'b0);
    chk("t5b_state", entry_state, 2'b01);
    run_sweep('0, 1'b0, SWEEP_CYC);

    // Reset in the middle of a press while the key stays down
    run_sweep(K9, 1'b0, SWEEP_CYC);
    run_sweep(K9, 1'b0, 8);
    do_reset();
    run_sweep(K9, 1'b0, SWEEP_CYC);
    chk("t6_no_early", kif.key_code, 4'd0);
    run_sweep(K9, 1'b0, SWEEP_CYC);
    chk("t6_key_code", kif.key_code, 4'd9);
    repeat (2) run_sweep('0, 1'b0, SWEEP_CYC);

    // Randomized key traffic with runs, bounces, chords and resets
    cur = '0;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(99) >= 45) begin
        pick = $urandom_range(99);
        if (pick < 35) cur = '0;
        else if (pick < 85) cur = 16'h0001 << $urandom_range(15);
        else cur = (16'h0001 << $urandom_range(15)) | (16'h0001 << $urandom_range(15));
      end
      sw = 1'($urandom_range(1));
      if ($urandom_range(99) < 3) begin
        run_sweep(cur, sw, $urandom_range(SWEEP_CYC - 1, 1));
        do_reset();
      end else begin
        run_sweep(cur, sw, SWEEP_CYC);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
